// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front-end: synchroniser, deserialiser and byte FIFO.
// Received bytes leave through a valid/ready port towards the core.
module uart_rx_frontend #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(CLK_DIV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          rx_in,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF =
        CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL =
        CNT_W'(CLK_DIV - 1);
    localparam logic [AW:0] DEPTH =
        (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic sync1, rxs, rxs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shreg, sh_n;
    logic             push, ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= sh_n;
            frame_err <= ferr;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        push    = 1'b0;
        ferr    = 1'b0;
        if (!ena) begin
            state_n = IDLE;
            cnt_n   = '0;
            bit_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state_n = START;
                        cnt_n   = HALF;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else if (!rxs) begin
                        state_n = DATA;
                        cnt_n   = FULL;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        sh_n  = {rxs, shreg[7:1]};
                        cnt_n = FULL;
                        bit_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state_n = STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, pop, wr;

    assign full       = (count == DEPTH);
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign wr         = push & (!full | pop);
    assign fifo_count = count;
    assign out_data   = out_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= push & full & !pop;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend with a queue-based reference model.
// Frames are scheduled as model events at their stop-sample cycle.
module tb_uart_rx_frontend;

    localparam int DIV = 8;
    localparam int DEP = 4;
    // 2 sync flops + edge-detect cycle + half bit + 9 full bits
    localparam int STOP_LAT = 3 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst, ena, rx_in, out_ready;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overflow;
    logic [2:0] fifo_count;

    uart_rx_frontend #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .rx_in      (rx_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] q[$];
    logic [7:0] mpop[$];
    int         cyc = 0;
    bit         exp_fe = 0, exp_ovf = 0;
    int         checks = 0, errors = 0;
    bit         chk_en = 0;
    int         fe_cnt = 0, ovf_cnt = 0;
    int         rise_cyc = -1, last_k = 0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // reference model: FIFO as a queue, frames as timed events
    always @(posedge clk) begin
        cyc++;
        exp_fe  = 0;
        exp_ovf = 0;
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready)
                mpop.push_back(q.pop_front());
            foreach (evq[i]) begin
                if (evq[i].cyc == cyc) begin
                    if (evq[i].kind == 2)
                        exp_fe = 1;
                    else if (q.size() < DEP)
                        q.push_back(evq[i].b);
                    else
                        exp_ovf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("fifo_count", fifo_count, q.size());
            if (q.size() != 0)
                chk("out_data", out_data, q[0]);
            chk("frame_err", frame_err, exp_fe);
            chk("overflow", overflow, exp_ovf);
            if (out_valid && !prev_valid && rise_cyc < 0)
                rise_cyc = cyc;
            if (frame_err) fe_cnt++;
            if (overflow) ovf_cnt++;
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [7:0] b, input bit stop_v);
        ev_t e;
        e.cyc  = cyc + STOP_LAT;
        e.kind = stop_v ? 1 : 2;
        e.b    = b;
        evq.push_back(e);
        last_k = cyc;
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_in = stop_v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        rx_in = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", out_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte, latency to visibility
        send(8'hA5, 1);
        chk("s1_latency", rise_cyc - last_k, 79);
        chk("s1_data", out_data, 8'hA5);
        chk("s1_count", fifo_count, 1);
        chk("s1_pulses", fe_cnt + ovf_cnt, 0);
        pop_n(1);

        // 2: fill, overflow on fifth, drain in order
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'h3C, 1);
        send(8'h81, 1);
        send(8'h55, 1);
        chk("s2_count", fifo_count, 4);
        chk("s2_ovf", ovf_cnt, 1);
        chk("s2_head", out_data, 8'h00);
        mpop.delete();
        pop_n(6);
        chk("s2_empty", out_valid, 0);
        chk("s2_order", {mpop[0], mpop[1], mpop[2], mpop[3]},
            32'h00FF3C81);

        // 3: two-cycle glitch is rejected
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("s3_count", fifo_count, 0);
        chk("s3_fe", fe_cnt, 0);

        // 4: framing error, long break, then clean byte
        send(8'h5A, 0);
        repeat (20 * DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("s4_fe", fe_cnt, 1);
        chk("s4_count0", fifo_count, 0);
        send(8'h12, 1);
        chk("s4_data", out_data, 8'h12);
        chk("s4_fe_once", fe_cnt, 1);

        // 5: full FIFO with a pop coinciding with the push
        send(8'h21, 1);
        send(8'h43, 1);
        send(8'h65, 1);
        chk("s5_full", fifo_count, 4);
        fork
            send(8'h77, 1);
            begin
                repeat (STOP_LAT - 1) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        chk("s5_count", fifo_count, 4);
        chk("s5_ovf", ovf_cnt, 1);
        chk("s5_head", out_data, 8'h21);
        pop_n(3);
        chk("s5_tail", out_data, 8'h77);
        pop_n(1);

        // 6a: ena dropped mid-frame (0x0F), then 0xC3
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        rx_in = 1'b0;
        ena = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        ena = 1'b1;
        repeat (DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("s6_abort", fifo_count, 0);
        send(8'hC3, 1);
        chk("s6_data", out_data, 8'hC3);
        pop_n(1);

        // 6b: reset mid-frame with two bytes queued
        send(8'hAA, 1);
        send(8'hBB, 1);
        chk("s6_queued", fifo_count, 2);
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_count", fifo_count, 0);
        chk("s6_rst_valid", out_valid, 0);
        rst = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        send(8'h3E, 1);
        chk("s6_recover", out_data, 8'h3E);
        chk("final_fe", fe_cnt, 1);
        chk("final_ovf", ovf_cnt, 1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial-input front-end inside the tt_um_aschrein_asic_0 user project, directly upstream of the core logic. It takes the raw asynchronous RX pin from ui_in[0] and synchronises it. It deserialises 8N1 UART frames and buffers received bytes in a small FIFO. Bytes go to the core over a valid/ready interface. The top level derives rst from ~rst_n.

Parameters:
CLK_DIV, 434, clock cycles per bit period (50 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.
CNT_W, $clog2(CLK_DIV), width of the bit-period counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
ena  input  1  design enable; when low, receiver held idle.
rx_in  input  1  raw asynchronous serial line; idle high.
out_data  output  8  FIFO head byte; valid only when out_valid=1.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head when out_valid & out_ready.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset (rst=1 at a clk edge): both synchroniser flops = 1, state=IDLE, counters=0, FIFO empty.
  - Resulting outputs: out_valid=0, fifo_count=0, frame_err=0, overflow=0, out_data=0.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- Synchroniser: 2 flops on rx_in; rxs is the second flop output. A third flop (rxs_d) is used for falling-edge detect. All decisions use rxs only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rxs_d=1 & rxs=0 with ena=1 -> START; counter loaded to CLK_DIV/2 - 1.
- START: counter counts down; at 0, sample rxs.
  - rxs=0 -> DATA, counter = CLK_DIV-1, bit index = 0.
  - rxs=1 -> IDLE (glitch rejected, no error).
- DATA: at each counter 0, shift rxs into shift register LSB-first and reload CLK_DIV-1. After bit index 7 is sampled -> STOP.
- STOP: at counter 0, sample rxs.
  - rxs=1: push byte into FIFO and return to IDLE. If FIFO is full and no pop happens in the same cycle, drop the byte and pulse overflow for 1 cycle.
  - rxs=0: pulse frame_err for 1 cycle, discard byte -> WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1 -> IDLE. This prevents a break condition from being read as back-to-back frames.
- Frame timing: all samples fall at mid-bit. With the start edge seen at cycle T0 (rxs low), the stop sample happens at T0 + CLK_DIV/2 + 9*CLK_DIV.
- Push latency: a pushed byte is visible (out_valid=1, out_data=byte) on the cycle after the stop sample.
- ena=0: FSM forced to IDLE on the next edge and any in-flight frame is aborted silently. The FIFO is retained and can still be popped.
- FIFO: registered read/write pointers, FIFO_DEPTH+1-state count; out_data driven from the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle: both take effect, count unchanged. This holds even when full, so no overflow.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_err and overflow never assert in the same cycle; both are 0 in all other cycles.

Test Plan:
All scenarios use CLK_DIV=8, FIFO_DEPTH=4, ena=1 unless stated.
1. Reset, idle line high, then send 0xA5 with out_ready=0 -> out_valid rises 1 cycle after the stop sample, out_data=0xA5, fifo_count=1, no error pulses.
2. Send 0x00, 0xFF, 0x3C, 0x81, 0x55 back-to-back with out_ready=0 -> fifo_count=4, and one overflow pulse at the fifth stop sample. Then hold out_ready=1 -> 0x00, 0xFF, 0x3C, 0x81 pop in order, then out_valid=0.
3. Glitch rx_in low for 2 cycles -> START rejects it; no push, no frame_err, FSM back in IDLE.
4. Send 0x5A with the stop bit held low, then hold the line low for 20 more bits, then release -> one frame_err pulse, FIFO unchanged. Then send 0x12 -> received correctly.
5. FIFO full, out_ready=1 held, send 0x77 -> push and pop coincide at the stop sample; no overflow, fifo_count stays 4, 0x77 is at the tail.
6. Drop ena at bit 4 of a frame, raise it after 3 bit times, then send 0xC3 -> no partial byte is pushed, 0xC3 is received. Separately, assert rst mid-frame with 2 bytes queued -> fifo_count=0, out_valid=0 on the next cycle.
